// File: rtl/his_pkg.sv
// Shared definitions for the histogram acquisition scheduler: default
// geometry taken from the SiFH parameter set, the no-hit code and the FSM states.
package his_pkg;

  localparam int HIS_NP           = 10;
  localparam int HIS_PIXEL_NUM    = 3;
  localparam int HIS_HITS_PER_PIX = 2;
  localparam int HIS_ACQ_NUM      = 2;

  localparam logic [HIS_NP-1:0] NOHIT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_GAP,
    S_DONE
  } sched_state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slot_counter.sv
// Nested hit / pixel / acquisition slot pointer. Advances one slot per pulse
// and flags the last slot of an acquisition and the last acquisition.
module slot_counter
  import his_pkg::*;
#(
  parameter int  PIXEL_NUM    = HIS_PIXEL_NUM,
  parameter int  HITS_PER_PIX = HIS_HITS_PER_PIX,
  parameter int  ACQ_NUM      = HIS_ACQ_NUM,
  localparam int PW           = cnt_w(PIXEL_NUM),
  localparam int AW           = $clog2(ACQ_NUM + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clear,
  input  logic          advance,
  output logic [PW-1:0] pix_cnt,
  output logic [AW-1:0] acq_cnt,
  output logic          acq_wrap,
  output logic          last_acq
);

  localparam int HW = cnt_w(HITS_PER_PIX);
  localparam logic [HW-1:0] HIT_LAST = HW'(HITS_PER_PIX - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_NUM - 1);
  localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_NUM - 1);
  localparam logic [AW-1:0] ACQ_MAX  = AW'(ACQ_NUM);

  logic [HW-1:0] hit_q, hit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [AW-1:0] acq_q, acq_d;
  logic          hit_wrap, pix_wrap;

  assign hit_wrap = (hit_q == HIT_LAST);
  assign pix_wrap = (pix_q == PIX_LAST);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    hit_d = hit_q;
    pix_d = pix_q;
    acq_d = acq_q;
    if (clear) begin
      hit_d = '0;
      pix_d = '0;
      acq_d = '0;
    end else if (advance) begin
      if (!hit_wrap) begin
        hit_d = hit_q + HW'(1);
      end else begin
        hit_d = '0;
        if (!pix_wrap) begin
          pix_d = pix_q + PW'(1);
        end else begin
          pix_d = '0;
          if (acq_q != ACQ_MAX) acq_d = acq_q + AW'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (res) begin
      hit_q <= '0;
      pix_q <= '0;
      acq_q <= '0;
    end else begin
      hit_q <= hit_d;
      pix_q <= pix_d;
      acq_q <= acq_d;
    end
  end

  assign pix_cnt  = pix_q;
  assign acq_cnt  = acq_q;
  assign acq_wrap = hit_wrap && pix_wrap;
  assign last_acq = (acq_q == ACQ_LAST);

endmodule

// File: rtl/his_acq_scheduler.sv
// Interleaves per-pixel TDC samples into the wrEn/data stream of the histogram
// builder, substituting NOHIT for silent slots and pacing acquisitions with a gap.
module his_acq_scheduler
  import his_pkg::*;
#(
  parameter int  NP           = HIS_NP,
  parameter int  PIXEL_NUM    = HIS_PIXEL_NUM,
  parameter int  HITS_PER_PIX = HIS_HITS_PER_PIX,
  parameter int  ACQ_NUM      = HIS_ACQ_NUM,
  parameter int  TIMEOUT      = 64,
  parameter int  GAP_CYC      = 4,
  localparam int AW           = $clog2(ACQ_NUM + 1)
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PIXEL_NUM-1:0]    pix_valid,
  input  logic [PIXEL_NUM*NP-1:0] pix_data,
  output logic [PIXEL_NUM-1:0]    pix_ready,
  output logic                    wrEn,
  output logic [NP-1:0]           data,
  output logic [AW-1:0]           acq_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = cnt_w(PIXEL_NUM);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = cnt_w(GAP_CYC);
  localparam logic [NP-1:0] NOHIT_CODE = '1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

  sched_state_e  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wr_en_q, wr_en_d;
  logic [NP-1:0] data_q, data_d;
  logic          done_q, done_d;

  logic [PW-1:0] pix_cnt;
  logic [AW-1:0] acq_cnt;
  logic          acq_wrap, last_acq, cnt_clear;
  logic          sel_valid, accept, tmo_hit, advance;
  logic [NP-1:0] sel_code;

  slot_counter #(
    .PIXEL_NUM   (PIXEL_NUM),
    .HITS_PER_PIX(HITS_PER_PIX),
    .ACQ_NUM     (ACQ_NUM)
  ) u_slot (
    .clk     (clk),
    .res     (res),
    .clear   (cnt_clear),
    .advance (advance),
    .pix_cnt (pix_cnt),
    .acq_cnt (acq_cnt),
    .acq_wrap(acq_wrap),
    .last_acq(last_acq)
  );

  // Ready depends only on state and pointer, never on the pixel's valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = '0;
    pix_ready = '0;
    for (int i = 0; i < PIXEL_NUM; i++) begin
      if (pix_cnt == PW'(i)) begin
        sel_valid    = pix_valid[i];
        sel_code     = pix_data[i*NP +: NP];
        pix_ready[i] = (state_q == S_COLLECT) && !res;
      end
    end
  end

  assign accept  = (state_q == S_COLLECT) && sel_valid && !res && !abort;
  assign tmo_hit = (state_q == S_COLLECT) && (tmo_q == TMO_LAST) && !abort;
  assign advance = accept || tmo_hit;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    wr_en_d   = 1'b0;
    data_d    = data_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d   = S_COLLECT;
          tmo_d     = '0;
          cnt_clear = 1'b1;
        end
      end
      S_COLLECT: begin
        if (advance) begin
          wr_en_d = 1'b1;
          // Real data wins over a timeout in the same cycle; NOHIT is reserved.
          if (accept) data_d = (sel_code == NOHIT_CODE) ? NOHIT_CODE - NP'(1) : sel_code;
          else        data_d = NOHIT_CODE;
          tmo_d = '0;
          if (acq_wrap) begin
            if (last_acq) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end else if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_COLLECT;
        else                   gap_d   = gap_q + GW'(1);
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      gap_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign wrEn    = wr_en_q;
  assign data    = data_q;
  assign done    = done_q;
  assign acq_idx = acq_cnt;
  assign busy    = (state_q == S_COLLECT) || (state_q == S_GAP);

endmodule
